// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse timing measurement block.
package pulse_meas_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DELAY,
      WAIT_WIDTH,
      HOLD
   } state_t;

   localparam int unsigned OVR_W = 8;

endpackage

// File: rtl/pulse_meas_sync.sv
// 2-FF synchroniser followed by a registered rise/fall edge detector.
// Strobes are forced low while suppress is high.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic suppress,
   input  logic din,
   output logic rise,
   output logic fall
);

   // sh[0], sh[1] are the synchroniser stages; sh[2] is the previous synchronised level
   logic [2:0] sh;

   always_ff @(posedge clk) begin
      if (reset) begin
         sh   <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sh   <= {sh[1:0], din};
         rise <= !suppress && sh[1] && !sh[2];
         fall <= !suppress && !sh[1] && sh[2];
      end
   end

endmodule

// File: rtl/pulse_meas.sv
// Measures trigger-to-pulse delay and pulse width in clock cycles,
// presenting each result pair behind a valid/ack handshake.
module pulse_meas
   import pulse_meas_pkg::*;
#(
   parameter int unsigned    N       = 32,
   parameter logic [N-1:0]   TIMEOUT = N'(32'hFFFF_FFFF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             trigger,
   input  logic             pulse_in,
   input  logic             meas_ack,
   output logic [N-1:0]     dl_meas,
   output logic [N-1:0]     wb_meas,
   output logic             meas_valid,
   output logic             meas_timeout,
   output logic             busy,
   output logic [OVR_W-1:0] overrun
);

   state_t       state, state_n;
   logic [N-1:0] cnt, cnt_n, cnt_inc;
   logic [N-1:0] dl_cap, dl_n;
   logic [N-1:0] dl_out_n, wb_out_n;
   logic         to_n;
   logic         ovr_hit;
   logic         timed_out;
   logic [1:0]   gate_cnt;
   logic         suppress;
   logic         trig_rise, trig_fall_unused;
   logic         pulse_rise, pulse_fall;

   // Synchroniser flops restart at 0, so a held-high input would look like an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         gate_cnt <= 2'd3;
      end else if (gate_cnt != '0) begin
         gate_cnt <= gate_cnt - 2'd1;
      end
   end

   assign suppress = (gate_cnt != '0);

   sync_edge u_trig (
      .clk      (clk),
      .reset    (reset),
      .suppress (suppress),
      .din      (trigger),
      .rise     (trig_rise),
      .fall     (trig_fall_unused)
   );

   sync_edge u_pulse (
      .clk      (clk),
      .reset    (reset),
      .suppress (suppress),
      .din      (pulse_in),
      .rise     (pulse_rise),
      .fall     (pulse_fall)
   );

   assign cnt_inc    = cnt + N'(1);
   assign timed_out  = (cnt_inc >= TIMEOUT);
   assign meas_valid = (state == HOLD);
   assign busy       = (state == WAIT_DELAY) || (state == WAIT_WIDTH);

   // A measured edge wins over a timeout landing in the same cycle
   always_comb begin
      state_n  = state;
      cnt_n    = cnt_inc;
      dl_n     = dl_cap;
      dl_out_n = dl_meas;
      wb_out_n = wb_meas;
      to_n     = meas_timeout;
      ovr_hit  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (trig_rise) begin
               if (enable) begin
                  if (pulse_rise) begin
                     dl_n    = '0;
                     state_n = WAIT_WIDTH;
                  end else begin
                     state_n = WAIT_DELAY;
                  end
               end else begin
                  ovr_hit = 1'b1;
               end
            end
         end
         WAIT_DELAY: begin
            ovr_hit = trig_rise;
            if (!enable) begin
               state_n = IDLE;
            end else if (pulse_rise) begin
               dl_n    = cnt_inc;
               cnt_n   = '0;
               state_n = WAIT_WIDTH;
            end else if (timed_out) begin
               dl_out_n = TIMEOUT;
               wb_out_n = '0;
               to_n     = 1'b1;
               state_n  = HOLD;
            end
         end
         WAIT_WIDTH: begin
            ovr_hit = trig_rise;
            if (!enable) begin
               state_n = IDLE;
            end else if (pulse_fall) begin
               dl_out_n = dl_cap;
               wb_out_n = cnt_inc;
               to_n     = 1'b0;
               state_n  = HOLD;
            end else if (timed_out) begin
               dl_out_n = dl_cap;
               wb_out_n = TIMEOUT;
               to_n     = 1'b1;
               state_n  = HOLD;
            end
         end
         HOLD: begin
            cnt_n   = '0;
            ovr_hit = trig_rise;
            if (meas_ack) begin
               state_n = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         dl_cap       <= '0;
         dl_meas      <= '0;
         wb_meas      <= '0;
         meas_timeout <= 1'b0;
         overrun      <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         dl_cap       <= dl_n;
         dl_meas      <= dl_out_n;
         wb_meas      <= wb_out_n;
         meas_timeout <= to_n;
         if (ovr_hit && (overrun != '1)) begin
            overrun <= overrun + OVR_W'(1);
         end
      end
   end

endmodule
